// File: rtl/mat3_dot_product_if.sv
// Element-pair input and result-bank output bundle for the 3x3 matrix multiplier.
// The source drives through master; the multiplier sits on slave.
interface mat3_dot_product_if #(
    parameter int EW = 16
);
    logic [2*EW-1:0]   in;
    logic              in_valid;
    logic [2*EW-1:0]   out;
    logic [3:0]        sel;
    logic              done;
    logic [9*2*EW-1:0] bank;

    modport master (
        output in,
        output in_valid,
        input  out,
        input  sel,
        input  done,
        input  bank
    );

    modport slave (
        input  in,
        input  in_valid,
        output out,
        output sel,
        output done,
        output bank
    );
endinterface

// File: rtl/mat3_dot_product.sv
// Unsigned 3x3 matrix multiply C = A x B: serial load of 9 (A,B) pairs, one C
// element per cycle into a parallel 9-entry result bank.
module mat3_dot_product #(
    parameter int EW = 16,
    parameter int N  = 3
) (
    input  logic              clk,
    input  logic              reset,
    mat3_dot_product_if.slave bus
);
    localparam int CW = 2 * EW;
    localparam int NE = N * N;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_COMP = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;

    logic [EW-1:0] r_a    [NE];
    logic [EW-1:0] r_b    [NE];
    logic [CW-1:0] r_bank [NE];
    logic [3:0]    r_idx;
    logic [3:0]    r_cidx;

    logic [1:0]    w_row;
    logic [1:0]    w_col;
    logic [3:0]    w_base;
    logic [3:0]    w_a_sel [N];
    logic [3:0]    w_b_sel [N];
    logic [CW-1:0] w_prod  [N];
    logic [CW-1:0] w_sum;
    wire  [NE*CW-1:0] w_bank;

    // Split cidx into row/col without a divider; w_base is 3*row.
    always_comb begin
        w_row  = (r_cidx >= 4'd6) ? 2'd2 : ((r_cidx >= 4'd3) ? 2'd1 : 2'd0);
        w_base = {2'b00, w_row} + {1'b0, w_row, 1'b0};
        w_col  = 2'(r_cidx - w_base);
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_dot
            assign w_a_sel[gi] = w_base + 4'(gi);
            assign w_b_sel[gi] = 4'(3 * gi) + {2'b00, w_col};
            assign w_prod[gi]  = CW'(r_a[w_a_sel[gi]]) * CW'(r_b[w_b_sel[gi]]);
        end
    endgenerate

    // Sum wraps modulo 2^CW by construction.
    assign w_sum = w_prod[0] + w_prod[1] + w_prod[2];

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_LOAD: if (bus.in_valid && (r_idx == 4'd8)) w_state_next = S_COMP;
            S_COMP: if (r_cidx == 4'd8)                  w_state_next = S_DONE;
            S_DONE: if (bus.in_valid)                    w_state_next = S_LOAD;
            default:                                     w_state_next = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx  <= '0;
            r_cidx <= '0;
            for (int k = 0; k < NE; k++) begin
                r_a[k]    <= '0;
                r_b[k]    <= '0;
                r_bank[k] <= '0;
            end
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_cidx <= '0;
                    if (bus.in_valid) begin
                        r_a[r_idx] <= bus.in[EW-1:0];
                        r_b[r_idx] <= bus.in[CW-1:EW];
                        r_idx      <= (r_idx == 4'd8) ? 4'd0 : r_idx + 4'd1;
                    end
                end
                S_COMP: begin
                    r_bank[r_cidx] <= w_sum;
                    r_cidx         <= (r_cidx == 4'd8) ? 4'd0 : r_cidx + 4'd1;
                end
                S_DONE: begin
                    // A new pair here is element 0 of the next run.
                    if (bus.in_valid) begin
                        r_a[0] <= bus.in[EW-1:0];
                        r_b[0] <= bus.in[CW-1:EW];
                        r_idx  <= 4'd1;
                    end
                end
                default: begin
                    r_idx  <= '0;
                    r_cidx <= '0;
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NE; gi++) begin : g_bank
            assign w_bank[CW*gi +: CW] = r_bank[gi];
        end
    endgenerate

    assign bus.bank = w_bank;
    assign bus.out  = (r_state == S_COMP) ? w_sum : '0;
    assign bus.sel  = (r_state == S_COMP) ? r_cidx : 4'hF;
    assign bus.done = (r_state == S_DONE);
endmodule

// File: tb/tb_mat3_dot_product.sv
// Scoreboard bench for mat3_dot_product: directed runs with hand-computed C values,
// checked by an independent monitor that pops the queue whenever sel marks a write.
module tb_mat3_dot_product;
    localparam int EW = 16;

    typedef logic [31:0] vec9_t [9];
    typedef struct {
        logic [3:0]  sel;
        logic [31:0] val;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mat3_dot_product_if #(.EW(EW)) bus ();

    mat3_dot_product #(.EW(EW), .N(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q [$];

    vec9_t basic_a = '{32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0};
    vec9_t basic_b = '{32'd17, 32'd16, 32'd15, 32'd14, 32'd13, 32'd12, 32'd11, 32'd10, 32'd9};
    vec9_t basic_c = '{32'd300, 32'd279, 32'd258, 32'd174, 32'd162, 32'd150, 32'd48, 32'd45, 32'd42};
    vec9_t ovf_ab  = '{default: 32'h0000FFFF};
    vec9_t ovf_c   = '{default: 32'hFFFA0003};
    vec9_t id_a    = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 32'd1};
    vec9_t id_b    = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic check_reset_state();
        check("rst_sel", 32'(bus.sel), 32'hF);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_out", bus.out, 32'd0);
        for (int k = 0; k < 9; k++) check("rst_bank", bus.bank[32*k +: 32], 32'd0);
    endtask

    // gap_after: pair index after which in_valid drops for gap_len cycles (-1: none).
    // junk: toggle in_valid with junk data during COMP.
    // probe: check bank retention against old_c while the run progresses.
    // abort_at: COMP cycle at which reset is pulsed (-1: none).
    task automatic run(input string tag, input vec9_t a, input vec9_t b, input vec9_t c,
                       input int gap_after, input int gap_len, input bit junk,
                       input bit probe, input vec9_t old_c, input int abort_at);
        int cyc;
        for (int k = 0; k < 9; k++) exp_q.push_back('{sel: 4'(k), val: c[k]});
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (probe && k == 1) begin
                check("load_done_low", 32'(bus.done), 32'd0);
                check("load_bank_kept", bus.bank[32*8 +: 32], old_c[8]);
            end
            bus.in       = {b[k][15:0], a[k][15:0]};
            bus.in_valid = 1'b1;
            if (k == gap_after) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
                repeat (gap_len - 1) @(negedge clk);
            end
        end
        @(negedge clk);
        bus.in       = 32'hDEAD_BEEF;
        bus.in_valid = junk;
        check("first_sel_latency", 32'(bus.sel), 32'd0);
        cyc = 0;
        while (!bus.done && cyc < 20) begin
            @(negedge clk);
            cyc++;
            bus.in       = 32'h1234_5678 + 32'(cyc);
            bus.in_valid = junk && (cyc <= 8) && (cyc % 2 == 0);
            if (probe && cyc == 4) begin
                check("bank_old_kept", bus.bank[32*4 +: 32], old_c[4]);
                check("bank_new_written", bus.bank[32*3 +: 32], c[3]);
            end
            if (cyc == abort_at) begin
                #2 reset = 1'b0;
                #1 check_reset_state();
                exp_q.delete();
                @(negedge clk);
                reset = 1'b1;
                return;
            end
        end
        bus.in_valid = 1'b0;
        check("done_latency", 32'(cyc), 32'd9);
        check("done_sel", 32'(bus.sel), 32'hF);
        check("done_out", bus.out, 32'd0);
        for (int k = 0; k < 9; k++) check({tag, "_bank"}, bus.bank[32*k +: 32], c[k]);
    endtask

    // Monitor: every write cycle must match the next queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && bus.sel != 4'hF) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write_sel", 32'(bus.sel), 32'hF);
                end else begin
                    e = exp_q.pop_front();
                    check("mon_sel", 32'(bus.sel), 32'(e.sel));
                    check("mon_out", bus.out, e.val);
                    $display("write sel=%0d out=%0d expected sel=%0d out=%0d",
                             bus.sel, bus.out, e.sel, e.val);
                end
            end
        end
    end

    initial begin
        bus.in       = '0;
        bus.in_valid = 1'b0;
        #1 check_reset_state();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        run("basic",    basic_a, basic_b, basic_c, -1, 0, 1'b0, 1'b0, basic_c, -1);
        run("gaps",     basic_a, basic_b, basic_c,  4, 2, 1'b0, 1'b0, basic_c, -1);
        run("overflow", ovf_ab,  ovf_ab,  ovf_c,   -1, 0, 1'b0, 1'b0, basic_c, -1);
        run("restart",  id_a,    id_b,    id_b,    -1, 0, 1'b0, 1'b1, ovf_c,   -1);
        run("junk",     basic_a, basic_b, basic_c, -1, 0, 1'b1, 1'b0, basic_c, -1);
        run("abort",    ovf_ab,  ovf_ab,  ovf_c,   -1, 0, 1'b0, 1'b0, basic_c,  3);
        run("after_rst", basic_a, basic_b, basic_c, -1, 0, 1'b0, 1'b0, basic_c, -1);

        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
